// File: rtl/mdu.sv
// Multiply/divide unit with architectural HI/LO registers.
// A mul/div result is computed at issue and committed after a fixed busy period.
module mdu #(
   parameter int MUL_CYCLES = 5,
   parameter int DIV_CYCLES = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mdu_start,
   input  logic [2:0]  mdu_mod,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic [31:0] HI_o,
   output logic [31:0] LO_o,
   output logic        busy
);

   localparam int MAXC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);

   typedef enum logic {IDLE, RUN} state_t;

   state_t          state_q;
   logic [CW-1:0]   cnt_q;
   logic [31:0]     hi_q, lo_q, hi_t_q, lo_t_q;
   logic            dz_q;

   logic            sgn, is_div, start_ok, b_zero;
   logic [63:0]     ea, eb, prod;
   logic [31:0]     ma, mb, uq, ur, q, r;

   assign sgn      = ~mdu_mod[0];
   assign is_div   = mdu_mod[1];
   assign start_ok = mdu_start & ~mdu_mod[2];
   assign b_zero   = (B == 32'd0);

   // One 64-bit multiplier serves both signednesses via operand extension.
   always_comb begin
      ea   = {{32{sgn & A[31]}}, A};
      eb   = {{32{sgn & B[31]}}, B};
      prod = ea * eb;
   end

   // Signed division on magnitudes; a zero divisor is replaced so the
   // divider never sees 0 (the result is discarded anyway).
   always_comb begin
      ma = (sgn && A[31]) ? -A : A;
      if (b_zero)
         mb = 32'd1;
      else
         mb = (sgn && B[31]) ? -B : B;
      uq = ma / mb;
      ur = ma % mb;
      q  = (sgn && (A[31] ^ B[31])) ? -uq : uq;
      r  = (sgn && A[31]) ? -ur : ur;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         hi_t_q  <= '0;
         lo_t_q  <= '0;
         dz_q    <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (start_ok) begin
                  hi_t_q  <= is_div ? r : prod[63:32];
                  lo_t_q  <= is_div ? q : prod[31:0];
                  dz_q    <= is_div & b_zero;
                  cnt_q   <= is_div ? CW'(DIV_CYCLES) : CW'(MUL_CYCLES);
                  state_q <= RUN;
               end else if (mdu_mod == 3'b100) begin
                  hi_q <= A;
               end else if (mdu_mod == 3'b101) begin
                  lo_q <= A;
               end
            end
            RUN: begin
               if (cnt_q == CW'(1)) begin
                  if (!dz_q) begin
                     hi_q <= hi_t_q;
                     lo_q <= lo_t_q;
                  end
                  cnt_q   <= '0;
                  state_q <= IDLE;
               end else begin
                  cnt_q <= cnt_q - CW'(1);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign HI_o = hi_q;
   assign LO_o = lo_q;
   assign busy = (state_q == RUN);

endmodule

// File: tb/tb_mdu.sv
// Directed self-checking bench for mdu: latency, arithmetic,
// divide-by-zero, mthi/mtlo, reset mid-operation and back-to-back issue.
module tb_mdu;

   logic        clk = 1'b0;
   logic        reset;
   logic        mdu_start;
   logic [2:0]  mdu_mod;
   logic [31:0] A, B;
   logic [31:0] HI_o, LO_o;
   logic        busy;

   int total = 0;
   int fails = 0;
   int n;

   mdu dut (
      .clk       (clk),
      .reset     (reset),
      .mdu_start (mdu_start),
      .mdu_mod   (mdu_mod),
      .A         (A),
      .B         (B),
      .HI_o      (HI_o),
      .LO_o      (LO_o),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic st, input logic [2:0] md,
                        input logic [31:0] a, input logic [31:0] b);
      mdu_start = st;
      mdu_mod   = md;
      A         = a;
      B         = b;
      step();
      mdu_start = 1'b0;
      mdu_mod   = 3'b111;
   endtask

   task automatic wait_idle(output int cnt);
      cnt = 0;
      while (busy && cnt < 40) begin
         cnt++;
         step();
      end
   endtask

   initial begin
      reset     = 1'b1;
      mdu_start = 1'b0;
      mdu_mod   = 3'b111;
      A         = '0;
      B         = '0;
      #1;
      check("rst_hi", HI_o, 32'h0);
      check("rst_lo", LO_o, 32'h0);
      check("rst_busy", {31'b0, busy}, 32'h0);
      step();
      reset = 1'b0;
      step();

      // mult -2 * 3
      issue(1'b1, 3'b000, 32'hFFFFFFFE, 32'd3);
      check("mult_busy_rise", {31'b0, busy}, 32'h1);
      check("mult_hi_pre", HI_o, 32'h0);
      wait_idle(n);
      check("mult_cycles", n, 32'd5);
      check("mult_hi", HI_o, 32'hFFFFFFFF);
      check("mult_lo", LO_o, 32'hFFFFFFFA);

      // multu same operands
      issue(1'b1, 3'b001, 32'hFFFFFFFE, 32'd3);
      check("multu_lo_pre", LO_o, 32'hFFFFFFFA);
      wait_idle(n);
      check("multu_cycles", n, 32'd5);
      check("multu_hi", HI_o, 32'h00000002);
      check("multu_lo", LO_o, 32'hFFFFFFFA);

      // div -7 / 2
      issue(1'b1, 3'b010, 32'hFFFFFFF9, 32'd2);
      wait_idle(n);
      check("div_cycles", n, 32'd10);
      check("div_lo", LO_o, 32'hFFFFFFFD);
      check("div_hi", HI_o, 32'hFFFFFFFF);

      // signed overflow case
      issue(1'b1, 3'b010, 32'h80000000, 32'hFFFFFFFF);
      wait_idle(n);
      check("divovf_cycles", n, 32'd10);
      check("divovf_lo", LO_o, 32'h80000000);
      check("divovf_hi", HI_o, 32'h0);

      // mthi/mtlo then divu by zero
      issue(1'b0, 3'b100, 32'h11, 32'h0);
      check("mthi_hi", HI_o, 32'h11);
      check("mthi_busy", {31'b0, busy}, 32'h0);
      issue(1'b0, 3'b101, 32'h22, 32'h0);
      check("mtlo_lo", LO_o, 32'h22);
      check("mtlo_hi_kept", HI_o, 32'h11);
      issue(1'b1, 3'b011, 32'd7, 32'd0);
      wait_idle(n);
      check("dz_cycles", n, 32'd10);
      check("dz_hi", HI_o, 32'h11);
      check("dz_lo", LO_o, 32'h22);

      // reset in the 3rd busy cycle of a mult
      issue(1'b0, 3'b100, 32'h55, 32'h0);
      issue(1'b0, 3'b101, 32'h66, 32'h0);
      issue(1'b1, 3'b000, 32'h10000, 32'h10000);
      step();
      step();
      check("rstmid_busy_pre", {31'b0, busy}, 32'h1);
      reset = 1'b1;
      #1;
      check("rstmid_busy", {31'b0, busy}, 32'h0);
      check("rstmid_hi", HI_o, 32'h0);
      check("rstmid_lo", LO_o, 32'h0);
      step();
      reset = 1'b0;
      repeat (8) step();
      check("rstpost_busy", {31'b0, busy}, 32'h0);
      check("rstpost_hi", HI_o, 32'h0);
      check("rstpost_lo", LO_o, 32'h0);

      // back-to-back: divu issued in the first idle cycle after a mult
      issue(1'b1, 3'b001, 32'd3, 32'd4);
      wait_idle(n);
      check("b2b_mult_lo", LO_o, 32'd12);
      issue(1'b1, 3'b011, 32'd100, 32'd7);
      n = 1;
      while (busy && n < 40) begin
         if (n == 3 || n == 10) begin
            mdu_start = 1'b1;
            mdu_mod   = 3'b000;
            A         = 32'd5;
            B         = 32'd5;
         end else begin
            mdu_start = 1'b0;
            mdu_mod   = 3'b111;
         end
         n++;
         step();
      end
      mdu_start = 1'b0;
      mdu_mod   = 3'b111;
      check("b2b_cycles", n - 1, 32'd10);
      check("b2b_hi", HI_o, 32'd2);
      check("b2b_lo", LO_o, 32'd14);
      step();
      check("commit_edge_start_ignored", {31'b0, busy}, 32'h0);
      check("b2b_lo_final", LO_o, 32'd14);

      $display("%0d/%0d checks passed", total - fails, total);
      $finish;
   end

endmodule
